// File: rtl/regfile_dump_pkg.sv
// Shared types and widths for the register-file debug dumper.
// DUMP_ADDR_HEADER_EN: when defined, each word is preceded by an address header byte.
package regfile_dump_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_W     = 8;

    // Upper bits of the header byte; the lower five carry the register address
    localparam logic [2:0]  HDR_PAD    = 3'b000;

`ifdef DUMP_ADDR_HEADER_EN
    localparam int unsigned SER_BYTES  = 5;
`else
    localparam int unsigned SER_BYTES  = 4;
`endif
    localparam int unsigned SER_W      = SER_BYTES * BYTE_W;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        NEXT
    } state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Control, debug read port and byte stream of the register dumper.
interface regfile_dump_if;
    import regfile_dump_pkg::*;

    logic                  start;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic [REG_ADDR_W-1:0] radddb;
    logic [WORD_W-1:0]     doutdb;
    logic [BYTE_W-1:0]     tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    // Dumper side
    modport master (
        input  start, abort, doutdb, tx_ready,
        output busy, done, radddb, tx_data, tx_valid
    );

    // Host / register file / transmitter side
    modport slave (
        output start, abort, doutdb, tx_ready,
        input  busy, done, radddb, tx_data, tx_valid
    );

endinterface

// File: rtl/regfile_dump_word_byte_serializer.sv
// Loads a word (optionally with header byte) and shifts it out MSB-first under valid/ready.
module word_byte_serializer
    import regfile_dump_pkg::*;
#(
    parameter int unsigned NBYTES = SER_BYTES
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_load,
    input  logic [NBYTES*BYTE_W-1:0] i_word,
    input  logic                     i_flush,
    input  logic                     i_tx_ready,
    output logic [BYTE_W-1:0]        o_tx_data,
    output logic                     o_tx_valid,
    output logic                     o_xfer_c,
    output logic                     o_last_c
);

    localparam int unsigned SH_W  = NBYTES * BYTE_W;
    localparam int unsigned CNT_W = $clog2(NBYTES);

    logic [SH_W-1:0]  r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;

    assign o_xfer_c   = r_valid && i_tx_ready;
    assign o_last_c   = o_xfer_c && (r_cnt == CNT_W'(NBYTES - 1));
    assign o_tx_data  = r_shift[SH_W-1 -: BYTE_W];
    assign o_tx_valid = r_valid;

    // Shift register and byte counter; valid drops only on a transfer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_word;
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (o_xfer_c) begin
            r_shift <= r_shift << BYTE_W;
            r_cnt   <= r_cnt + 1'b1;
            if (o_last_c || i_flush) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_dump.sv
// Walks FIRST_REG..LAST_REG over the debug read port and streams each word as bytes.
// DUMP_ADDR_HEADER_EN: when defined, a {HDR_PAD, addr} byte precedes each word.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int unsigned FIRST_REG    = 0,
    parameter int unsigned LAST_REG     = 31,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic           clock,
    input  logic           reset,
    regfile_dump_if.master bus
);

    localparam int unsigned WAIT_W = $clog2(READ_LATENCY + 2);

    state_t                r_state;
    state_t                w_next;
    logic [REG_ADDR_W-1:0] r_addr;
    logic [REG_ADDR_W-1:0] r_radddb;
    logic [WAIT_W-1:0]     r_wait;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_abort_pend;

    logic                  w_load_addr;
    logic                  w_inc_addr;
    logic                  w_ser_load;
    logic                  w_flush;
    logic                  w_done_set;
    logic                  w_xfer_c;
    logic                  w_last_c;
    logic [SER_W-1:0]      w_ser_word;
    logic [BYTE_W-1:0]     w_tx_data;
    logic                  w_tx_valid;

`ifdef DUMP_ADDR_HEADER_EN
    assign w_ser_word = {HDR_PAD, r_addr, bus.doutdb};
`else
    assign w_ser_word = bus.doutdb;
`endif

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.radddb   = r_radddb;
    assign bus.tx_data  = w_tx_data;
    assign bus.tx_valid = w_tx_valid;

    word_byte_serializer #(
        .NBYTES (SER_BYTES)
    ) u_ser (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_ser_load),
        .i_word     (w_ser_word),
        .i_flush    (w_flush),
        .i_tx_ready (bus.tx_ready),
        .o_tx_data  (w_tx_data),
        .o_tx_valid (w_tx_valid),
        .o_xfer_c   (w_xfer_c),
        .o_last_c   (w_last_c)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        w_next      = r_state;
        w_load_addr = 1'b0;
        w_inc_addr  = 1'b0;
        w_ser_load  = 1'b0;
        w_flush     = 1'b0;
        w_done_set  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next      = READ;
                    w_load_addr = 1'b1;
                end
            end
            READ: begin
                if (bus.abort) begin
                    w_next = IDLE;
                end else if (r_wait == WAIT_W'(READ_LATENCY)) begin
                    w_next     = SEND;
                    w_ser_load = 1'b1;
                end
            end
            SEND: begin
                // An abort takes effect only once the presented byte has gone
                if (w_xfer_c && (bus.abort || r_abort_pend)) begin
                    w_next  = IDLE;
                    w_flush = 1'b1;
                end else if (w_last_c) begin
                    w_next = NEXT;
                end
            end
            NEXT: begin
                if (bus.abort) begin
                    w_next = IDLE;
                end else if (r_addr == REG_ADDR_W'(LAST_REG)) begin
                    w_next     = IDLE;
                    w_done_set = 1'b1;
                end else begin
                    w_next     = READ;
                    w_inc_addr = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Address, read-wait counter, status outputs and pending abort
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr       <= REG_ADDR_W'(FIRST_REG);
            r_radddb     <= '0;
            r_wait       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            r_busy <= (w_next != IDLE);
            r_done <= w_done_set;
            r_wait <= (r_state == READ && w_next == READ) ? r_wait + 1'b1 : '0;
            if (w_load_addr) begin
                r_addr   <= REG_ADDR_W'(FIRST_REG);
                r_radddb <= REG_ADDR_W'(FIRST_REG);
            end else if (w_inc_addr) begin
                r_addr   <= r_addr + 1'b1;
                r_radddb <= r_addr + 1'b1;
            end
            if (w_next == IDLE) begin
                r_abort_pend <= 1'b0;
            end else if (r_state == SEND && bus.abort) begin
                r_abort_pend <= 1'b1;
            end
        end
    end

endmodule
